// File: rtl/parity_uart_tx.sv
// 8-bit UART transmitter with a parity bit: start, d[0..7] LSB first, parity, stop.
// Each bit lasts CLKS_PER_BIT clocks. tx, busy and frame_done come straight from flops.
module parity_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter bit          ODD_PARITY   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] d,
   input  logic       d_valid,
   output logic       d_ready,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(CLKS_PER_BIT - 2);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;
   logic             parity_bit;
   logic             bit_end;

   assign bit_end = (baud_cnt == LAST_CNT);

   // d_ready is forced low while rst is high, so it can rise on the first cycle after reset.
   assign d_ready = (state == IDLE) && !rst;

   // Single FSM. tx is always loaded with the next bit value one clock before it goes on the line.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_idx  <= '0;
               tx       <= 1'b1;
               busy     <= 1'b0;
               if (d_valid) begin
                  shift_reg <= d;
                  tx        <= 1'b0;
                  busy      <= 1'b1;
                  state     <= START;
               end
            end

            START: begin
               if (bit_end) begin
                  baud_cnt   <= '0;
                  bit_idx    <= '0;
                  parity_bit <= (^shift_reg) ^ ODD_PARITY;
                  tx         <= shift_reg[0];
                  shift_reg  <= {1'b0, shift_reg[7:1]};
                  state      <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= parity_bit;
                     state <= PARITY;
                  end else begin
                     bit_idx   <= bit_idx + 3'd1;
                     tx        <= shift_reg[0];
                     shift_reg <= {1'b0, shift_reg[7:1]};
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            PARITY: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  tx       <= 1'b1;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            STOP: begin
               // frame_done is raised one clock early so that it is high during the last stop-bit cycle.
               if (bit_end) begin
                  baud_cnt <= '0;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
                  if (baud_cnt == PRE_LAST_CNT) begin
                     frame_done <= 1'b1;
                  end
               end
            end

            default: begin
               tx    <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_parity_uart_tx.sv
// Directed bench for parity_uart_tx with CLKS_PER_BIT=4. It runs one even-parity instance and one odd-parity instance.
// A mid-bit receiver model rebuilds each frame and compares it with the byte that was sent.
module tb_parity_uart_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] d;
   logic       d_valid;
   logic       d_valid_odd;
   logic       d_ready, tx, busy, frame_done;
   logic       d_ready_odd, tx_odd, busy_odd, frame_done_odd;

   int error_count = 0;
   int check_count = 0;

   always #5 clk = ~clk;

   parity_uart_tx #(.CLKS_PER_BIT(4), .ODD_PARITY(1'b0)) dut_even (
      .clk        (clk),
      .rst        (rst),
      .d          (d),
      .d_valid    (d_valid),
      .d_ready    (d_ready),
      .tx         (tx),
      .busy       (busy),
      .frame_done (frame_done)
   );

   parity_uart_tx #(.CLKS_PER_BIT(4), .ODD_PARITY(1'b1)) dut_odd (
      .clk        (clk),
      .rst        (rst),
      .d          (d),
      .d_valid    (d_valid_odd),
      .d_ready    (d_ready_odd),
      .tx         (tx_odd),
      .busy       (busy_odd),
      .frame_done (frame_done_odd)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for d_ready, then performs one handshake. It returns on cycle 1 of the frame.
   task automatic applyStimulus(input bit sel, input logic [7:0] value, input bit hold_valid);
      int waited = 0;
      while (((sel ? d_ready_odd : d_ready) !== 1'b1) && waited < 100) begin
         tick();
         waited++;
      end
      checkOutput("ready_before_send", sel ? d_ready_odd : d_ready, 1);
      d = value;
      if (sel) d_valid_odd = 1'b1;
      else     d_valid     = 1'b1;
      tick();
      if (!hold_valid) begin
         d_valid     = 1'b0;
         d_valid_odd = 1'b0;
      end
   endtask

   // Receiver model: starts on cycle 1 after a handshake and ends on cycle 45, which must be idle.
   // Modes: 0 = quiet, 1 = pulse d_valid with new d mid-frame, 2 = only change d mid-frame.
   task automatic receiveFrame(input bit sel, input logic [7:0] expected_byte, input logic expected_parity,
                               input int mode, input logic [7:0] other_d, input string name);
      logic [10:0] exp_bits;
      logic [10:0] rx_bits;
      logic        line;
      int          hold_err = 0;
      exp_bits = {1'b1, expected_parity, expected_byte, 1'b0};
      rx_bits  = '0;
      for (int cyc = 1; cyc <= 44; cyc++) begin
         int b;
         if (cyc > 1) tick();
         b    = (cyc - 1) / 4;
         line = sel ? tx_odd : tx;
         if (line !== exp_bits[b]) hold_err++;
         if ((sel ? busy_odd : busy) !== 1'b1) hold_err++;
         if ((sel ? frame_done_odd : frame_done) !== (cyc == 44)) hold_err++;
         if ((sel ? d_ready_odd : d_ready) !== 1'b0) hold_err++;
         if ((cyc - 1) % 4 == 1) rx_bits[b] = line;
         if (mode != 0 && cyc == 14) begin
            d = other_d;
            if (mode == 1) d_valid = 1'b1;
         end
         if (mode == 1 && cyc == 17) d_valid = 1'b0;
      end
      checkOutput({name, "_start"},  rx_bits[0], 0);
      checkOutput({name, "_data"},   rx_bits[8:1], expected_byte);
      checkOutput({name, "_parity"}, rx_bits[9], expected_parity);
      checkOutput({name, "_stop"},   rx_bits[10], 1);
      checkOutput({name, "_cycle_errors"}, hold_err, 0);
      tick();
      checkOutput({name, "_idle_tx"},    sel ? tx_odd : tx, 1);
      checkOutput({name, "_idle_busy"},  sel ? busy_odd : busy, 0);
      checkOutput({name, "_idle_done"},  sel ? frame_done_odd : frame_done, 0);
      checkOutput({name, "_idle_ready"}, sel ? d_ready_odd : d_ready, 1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int quiet_err;
      rst         = 1'b1;
      d           = 8'h00;
      d_valid     = 1'b0;
      d_valid_odd = 1'b0;
      repeat (3) tick();
      checkOutput("rst_tx",         tx, 1);
      checkOutput("rst_busy",       busy, 0);
      checkOutput("rst_frame_done", frame_done, 0);
      checkOutput("rst_ready",      d_ready, 0);
      checkOutput("rst_tx_odd",     tx_odd, 1);
      rst = 1'b0;
      #1;
      checkOutput("ready_after_rst", d_ready, 1);

      $display("[TB] frame 0xA5, even parity");
      applyStimulus(1'b0, 8'hA5, 1'b0);
      receiveFrame(1'b0, 8'hA5, 1'b0, 0, 8'h00, "a5");

      $display("[TB] frame 0x07, even and odd parity");
      applyStimulus(1'b0, 8'h07, 1'b0);
      receiveFrame(1'b0, 8'h07, 1'b1, 0, 8'h00, "07_even");
      applyStimulus(1'b1, 8'h07, 1'b0);
      receiveFrame(1'b1, 8'h07, 1'b0, 0, 8'h00, "07_odd");

      $display("[TB] back-to-back 0x00 then 0xFF with d_valid held");
      applyStimulus(1'b0, 8'h00, 1'b1);
      receiveFrame(1'b0, 8'h00, 1'b0, 2, 8'hFF, "b2b_00");
      tick();
      d_valid = 1'b0;
      receiveFrame(1'b0, 8'hFF, 1'b0, 0, 8'h00, "b2b_ff");

      $display("[TB] d and d_valid disturbed during DATA");
      applyStimulus(1'b0, 8'h13, 1'b0);
      receiveFrame(1'b0, 8'h13, 1'b1, 1, 8'hEC, "disturb");
      quiet_err = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (tx !== 1'b1 || busy !== 1'b0) quiet_err++;
      end
      checkOutput("no_restart", quiet_err, 0);

      $display("[TB] reset at cycle 20 of a frame");
      applyStimulus(1'b0, 8'hC3, 1'b0);
      repeat (19) tick();
      rst = 1'b1;
      tick();
      checkOutput("abort_tx",    tx, 1);
      checkOutput("abort_busy",  busy, 0);
      checkOutput("abort_done",  frame_done, 0);
      checkOutput("abort_ready", d_ready, 0);
      rst = 1'b0;
      #1;
      checkOutput("abort_ready_after", d_ready, 1);
      quiet_err = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) quiet_err++;
      end
      checkOutput("abort_quiet", quiet_err, 0);
      applyStimulus(1'b0, 8'h3C, 1'b0);
      receiveFrame(1'b0, 8'h3C, 1'b0, 0, 8'h00, "after_rst");

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule
